amostrador_sensores: RTL and testbench
======================================

Name: amostrador_sensores

Overview:
Sensor acquisition stage directly upstream of controlador_estufa. It receives a time-multiplexed stream of 4-bit sensor readings and averages 2**AMOSTRAS_LOG2 samples per channel. Once every channel is complete, it publishes stable temperatura, pH, luminosidade and umidade values and drives enable for the controller. A watchdog flags a missing or stalled sensor.

Parameters:
AMOSTRAS_LOG2, 2, log2 of samples averaged per channel (4 samples by default)
TIMEOUT, 1000, maximum clock cycles allowed in COLETA before a frame is abandoned

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
sensor_valido  input  1  sample present on sensor_id/sensor_dado
sensor_id  input  2  channel: 0 temperatura, 1 pH, 2 luminosidade, 3 umidade
sensor_dado  input  4  raw sample value, unsigned
sensor_pronto  output  1  block accepts a sample this cycle
temperatura  output  4  averaged temperature
pH  output  4  averaged pH
luminosidade  output  4  averaged luminosity
umidade  output  4  averaged humidity
enable  output  1  level; published values are valid
atualizado  output  1  one-cycle pulse when new values are published
erro_timeout  output  1  sticky watchdog flag

Behaviour:
- Reset (reset=0, async): state COLETA; all accumulators, counters and watchdog cleared; all four value outputs 0; enable=0; atualizado=0; erro_timeout=0. Reset mid-frame discards the partial frame.
- Handshake: a sample is accepted on a rising edge with sensor_valido=1 and sensor_pronto=1. sensor_pronto=1 only in COLETA; the source must hold its data while sensor_pronto=0.
- Per channel: accumulator of width 4+AMOSTRAS_LOG2 (no overflow possible); sample counter of width AMOSTRAS_LOG2+1.
- An accepted sample for a channel already at 2**AMOSTRAS_LOG2 samples is consumed and ignored; the accumulator is unchanged.
- States:
  - COLETA: accept samples. When the accepted sample completes the last channel, go to MEDIA. If the watchdog reaches TIMEOUT-1 with the frame incomplete, go to ERRO.
  - MEDIA (1 cycle): compute avg = acc >> AMOSTRAS_LOG2 (truncation) into holding registers. Go to PUBLICA.
  - PUBLICA (1 cycle): copy averages to the outputs; atualizado=1; enable=1; erro_timeout=0; clear accumulators and counters. Go to COLETA.
  - ERRO (1 cycle): erro_timeout=1; enable=0; value outputs keep their last values; clear accumulators and counters. Go to COLETA.
- Latency: the completing sample is accepted at edge k. Outputs, enable and atualizado change at edge k+2. sensor_pronto is low for exactly 2 cycles per frame.
- Watchdog: clears on every entry to COLETA and counts each COLETA cycle.
- Simultaneous completion and watchdog expiry: completion wins; the frame is published and there is no error.
- enable stays at 1 across frames until an ERRO or reset. Value outputs change only in PUBLICA.
- sensor_id/sensor_dado are ignored when sensor_valido=0.

Test Plan:
1. Reset, then send temperatura 6,6,7,7; pH 6×4; luminosidade 8×4; umidade 8×4, back-to-back → two cycles after the last accept: temperatura=6, pH=6, luminosidade=8, umidade=8; enable=1; atualizado high for exactly 1 cycle.
2. Send channel samples interleaved in the order 3,0,2,1 repeated 4 times with 15,15,15,14 on channel 0 → temperatura=14 (59>>2), verifying truncation and full-range accumulation.
3. Send a 5th sample (value 15) on channel 0 after its 4 samples of value 2, then complete the other channels → temperatura=2 (extra sample ignored); sensor_pronto=0 during the MEDIA/PUBLICA cycles.
4. Set TIMEOUT=50 and send only channels 0–2 → erro_timeout=1 at cycle 50, enable=0, outputs retain the previous frame; a following full frame clears erro_timeout and sets enable=1.
5. Make the completing accept land on the watchdog's final cycle → frame published, erro_timeout stays 0.
6. Assert reset=0 mid-frame after 2 samples per channel, release, then send a full frame of value 3 → all outputs 3 (no residue); outputs and enable read 0 while reset is low.

Source files
------------

// File: rtl/amostrador_sensores.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : amostrador_sensores
// Description : Averages 2**AMOSTRAS_LOG2 multiplexed 4-bit samples per
//               channel and publishes them to controlador_estufa.
// Revision    : 1.0 - initial release
// ============================================================================
module amostrador_sensores #(
    parameter int AMOSTRAS_LOG2 = 2,
    parameter int TIMEOUT       = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sensor_valido,
    input  logic [1:0] sensor_id,
    input  logic [3:0] sensor_dado,
    output logic       sensor_pronto,
    output logic [3:0] temperatura,
    output logic [3:0] pH,
    output logic [3:0] luminosidade,
    output logic [3:0] umidade,
    output logic       enable,
    output logic       atualizado,
    output logic       erro_timeout
);

    localparam int c_ACC_W = 4 + AMOSTRAS_LOG2;
    localparam int c_CNT_W = AMOSTRAS_LOG2 + 1;
    localparam int c_WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [c_CNT_W-1:0] c_N        = c_CNT_W'(1 << AMOSTRAS_LOG2);
    localparam logic [c_CNT_W-1:0] c_N_MENOS1 = c_CNT_W'((1 << AMOSTRAS_LOG2) - 1);
    localparam logic [c_WD_W-1:0]  c_WD_MAX   = c_WD_W'(TIMEOUT - 1);

    localparam logic [1:0] c_COLETA  = 2'd0;
    localparam logic [1:0] c_MEDIA   = 2'd1;
    localparam logic [1:0] c_PUBLICA = 2'd2;
    localparam logic [1:0] c_ERRO    = 2'd3;

    logic [1:0]         r_estado;
    logic [c_ACC_W-1:0] r_acc   [4];
    logic [c_CNT_W-1:0] r_cnt   [4];
    logic [3:0]         r_media [4];
    logic [3:0]         r_saida [4];
    logic [c_WD_W-1:0]  r_wd;
    logic               r_enable;
    logic               r_atualizado;
    logic               r_erro;

    logic [3:0] w_cheio;
    logic [3:0] w_fecha;
    logic       w_aceita;
    logic       w_conta;
    logic       w_completa;

    assign sensor_pronto = (r_estado == c_COLETA);
    assign w_aceita      = sensor_valido & sensor_pronto;
    // Samples beyond a full channel are consumed without touching the sum
    assign w_conta       = w_aceita & ~w_cheio[sensor_id];

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_canal
        assign w_cheio[gi] = (r_cnt[gi] == c_N);
        assign w_fecha[gi] = w_cheio[gi] |
                             (w_conta & (sensor_id == 2'(gi)) & (r_cnt[gi] == c_N_MENOS1));
    end

    assign w_completa = &w_fecha;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado     <= c_COLETA;
            r_wd         <= '0;
            r_enable     <= 1'b0;
            r_atualizado <= 1'b0;
            r_erro       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_acc[i]   <= '0;
                r_cnt[i]   <= '0;
                r_media[i] <= '0;
                r_saida[i] <= '0;
            end
        end else begin
            r_atualizado <= 1'b0;
            case (r_estado)
                c_COLETA: begin
                    if (w_conta) begin
                        r_acc[sensor_id] <= r_acc[sensor_id] + c_ACC_W'(sensor_dado);
                        r_cnt[sensor_id] <= r_cnt[sensor_id] + 1'b1;
                    end
                    // Completion takes priority over an expiring watchdog
                    if (w_completa) begin
                        r_estado <= c_MEDIA;
                    end else if (r_wd == c_WD_MAX) begin
                        r_estado <= c_ERRO;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                c_MEDIA: begin
                    for (int i = 0; i < 4; i++) begin
                        r_media[i] <= r_acc[i][c_ACC_W-1:AMOSTRAS_LOG2];
                    end
                    r_estado <= c_PUBLICA;
                end
                c_PUBLICA: begin
                    for (int i = 0; i < 4; i++) begin
                        r_saida[i] <= r_media[i];
                        r_acc[i]   <= '0;
                        r_cnt[i]   <= '0;
                    end
                    r_atualizado <= 1'b1;
                    r_enable     <= 1'b1;
                    r_erro       <= 1'b0;
                    r_wd         <= '0;
                    r_estado     <= c_COLETA;
                end
                c_ERRO: begin
                    for (int i = 0; i < 4; i++) begin
                        r_acc[i] <= '0;
                        r_cnt[i] <= '0;
                    end
                    r_erro   <= 1'b1;
                    r_enable <= 1'b0;
                    r_wd     <= '0;
                    r_estado <= c_COLETA;
                end
                default: begin
                    r_estado <= c_COLETA;
                end
            endcase
        end
    end

    assign temperatura  = r_saida[0];
    assign pH           = r_saida[1];
    assign luminosidade = r_saida[2];
    assign umidade      = r_saida[3];
    assign enable       = r_enable;
    assign atualizado   = r_atualizado;
    assign erro_timeout = r_erro;

endmodule
`default_nettype wire

// File: tb/tb_amostrador_sensores.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_amostrador_sensores
// Description : Scoreboard bench for amostrador_sensores (directed frames).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_amostrador_sensores;

    localparam int c_TO = 50;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       sensor_valido = 1'b0;
    logic [1:0] sensor_id = 2'd0;
    logic [3:0] sensor_dado = 4'd0;
    logic       sensor_pronto;
    logic [3:0] temperatura, pH, luminosidade, umidade;
    logic       enable, atualizado, erro_timeout;

    amostrador_sensores #(
        .AMOSTRAS_LOG2(2),
        .TIMEOUT      (c_TO)
    ) u_dut (
        .clock        (clock),
        .reset        (reset),
        .sensor_valido(sensor_valido),
        .sensor_id    (sensor_id),
        .sensor_dado  (sensor_dado),
        .sensor_pronto(sensor_pronto),
        .temperatura  (temperatura),
        .pH           (pH),
        .luminosidade (luminosidade),
        .umidade      (umidade),
        .enable       (enable),
        .atualizado   (atualizado),
        .erro_timeout (erro_timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        int t, p, l, u, en, er, cmin, cmax;
    } exp_t;

    exp_t q[$];
    int   edge_cnt = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   last_acc = 0;
    int   last_evt = 0;
    int   pend_pulse = 0;
    logic prev_erro = 1'b0;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nome, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", nome, act, exp_v, edge_cnt);
        end
    endtask

    task automatic push_exp(input int t, p, l, u, en, er, cmin, cmax);
        exp_t e;
        e.t = t; e.p = p; e.l = l; e.u = u;
        e.en = en; e.er = er; e.cmin = cmin; e.cmax = cmax;
        q.push_back(e);
    endtask

    // Monitor: every publish pulse or new watchdog error pops one expectation
    always @(negedge clock) begin
        if (reset) begin
            if (pend_pulse != 0) begin
                chk("atualizado_width", int'(atualizado), 0);
                pend_pulse = 0;
            end
            if (atualizado || (erro_timeout && !prev_erro)) begin
                last_evt = edge_cnt;
                if (q.size() == 0) begin
                    chk("unexpected_event", q.size(), 1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("atualizado", int'(atualizado), (e.er == 0) ? 1 : 0);
                    chk("temperatura", int'(temperatura), e.t);
                    chk("pH", int'(pH), e.p);
                    chk("luminosidade", int'(luminosidade), e.l);
                    chk("umidade", int'(umidade), e.u);
                    chk("enable", int'(enable), e.en);
                    chk("erro_timeout", int'(erro_timeout), e.er);
                    chk("event_edge_in_window",
                        int'(edge_cnt >= e.cmin && edge_cnt <= e.cmax), 1);
                    if (atualizado) pend_pulse = 1;
                end
            end
        end
        prev_erro = erro_timeout;
    end

    task automatic send(input logic [1:0] id, input logic [3:0] d);
        int w;
        w = 0;
        @(negedge clock);
        sensor_valido = 1'b1;
        sensor_id     = id;
        sensor_dado   = d;
        while (!sensor_pronto && w < 10) begin
            @(negedge clock);
            w++;
        end
        if (w >= 10) chk("pronto_stuck_low", int'(sensor_pronto), 1);
        @(posedge clock);
        #1;
        last_acc      = edge_cnt;
        sensor_valido = 1'b0;
    endtask

    task automatic send4(input logic [1:0] id, input logic [3:0] a, b, c, d);
        send(id, a); send(id, b); send(id, c); send(id, d);
    endtask

    // Expected publish lands two edges after the completing accept
    task automatic expect_pub(input int t, p, l, u);
        push_exp(t, p, l, u, 1, 0, last_acc + 2, last_acc + 2);
    endtask

    task automatic wait_empty();
        int w;
        w = 0;
        while (q.size() != 0 && w < 200) begin
            @(negedge clock);
            w++;
        end
        if (q.size() != 0) chk("scoreboard_drain_timeout", q.size(), 0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_temperatura"}, int'(temperatura), 0);
        chk({tag, "_pH"}, int'(pH), 0);
        chk({tag, "_luminosidade"}, int'(luminosidade), 0);
        chk({tag, "_umidade"}, int'(umidade), 0);
        chk({tag, "_enable"}, int'(enable), 0);
        chk({tag, "_atualizado"}, int'(atualizado), 0);
    endtask

    initial begin
        int e_pub;
        int e_err;

        // Reset state
        repeat (3) @(negedge clock);
        chk_zero_outputs("reset");
        chk("reset_erro", int'(erro_timeout), 0);
        reset = 1'b1;
        @(negedge clock);
        chk("pronto_after_reset", int'(sensor_pronto), 1);

        // 1: back-to-back channels
        send4(2'd0, 4'd6, 4'd6, 4'd7, 4'd7);
        send4(2'd1, 4'd6, 4'd6, 4'd6, 4'd6);
        send4(2'd2, 4'd8, 4'd8, 4'd8, 4'd8);
        send4(2'd3, 4'd8, 4'd8, 4'd8, 4'd8);
        expect_pub(6, 6, 8, 8);

        // 2: interleaved 3,0,2,1; channel 0 sums 59
        send(2'd3, 4'd0);  send(2'd0, 4'd15); send(2'd2, 4'd10); send(2'd1, 4'd7);
        send(2'd3, 4'd1);  send(2'd0, 4'd15); send(2'd2, 4'd11); send(2'd1, 4'd7);
        send(2'd3, 4'd2);  send(2'd0, 4'd15); send(2'd2, 4'd12); send(2'd1, 4'd7);
        send(2'd3, 4'd3);  send(2'd0, 4'd14); send(2'd2, 4'd13); send(2'd1, 4'd8);
        expect_pub(14, 7, 11, 1);

        // 3: fifth sample on a full channel is dropped
        send4(2'd0, 4'd2, 4'd2, 4'd2, 4'd2);
        send(2'd0, 4'd15);
        send4(2'd1, 4'd5, 4'd5, 4'd5, 4'd5);
        send4(2'd2, 4'd9, 4'd9, 4'd9, 4'd9);
        send4(2'd3, 4'd1, 4'd1, 4'd1, 4'd1);
        expect_pub(2, 5, 9, 1);
        e_pub = last_acc + 2;
        @(negedge clock); chk("pronto_in_media", int'(sensor_pronto), 0);
        @(negedge clock); chk("pronto_in_publica", int'(sensor_pronto), 0);
        @(negedge clock); chk("pronto_back_in_coleta", int'(sensor_pronto), 1);

        // 4: umidade never arrives -> watchdog error, previous values held
        push_exp(2, 5, 9, 1, 0, 1, e_pub + c_TO, e_pub + c_TO + 2);
        send4(2'd0, 4'd9, 4'd9, 4'd9, 4'd9);
        send4(2'd1, 4'd9, 4'd9, 4'd9, 4'd9);
        send4(2'd2, 4'd9, 4'd9, 4'd9, 4'd9);
        wait_empty();
        e_err = last_evt;

        // 5: completing accept on the watchdog's final cycle still publishes
        send4(2'd0, 4'd12, 4'd12, 4'd12, 4'd12);
        send4(2'd1, 4'd3, 4'd4, 4'd3, 4'd4);
        send4(2'd2, 4'd0, 4'd0, 4'd0, 4'd0);
        send(2'd3, 4'd15); send(2'd3, 4'd15); send(2'd3, 4'd15);
        while (edge_cnt < e_err + c_TO - 1) begin
            @(posedge clock);
            #1;
        end
        send(2'd3, 4'd15);
        chk("final_cycle_accept_edge", last_acc, e_err + c_TO);
        expect_pub(12, 3, 0, 15);
        wait_empty();

        // 6: reset mid-frame discards partial sums
        send(2'd0, 4'd15); send(2'd1, 4'd15); send(2'd2, 4'd15); send(2'd3, 4'd15);
        send(2'd0, 4'd15); send(2'd1, 4'd15); send(2'd2, 4'd15); send(2'd3, 4'd15);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk_zero_outputs("midreset");
        @(negedge clock);
        chk_zero_outputs("midreset_hold");
        reset = 1'b1;
        send4(2'd0, 4'd3, 4'd3, 4'd3, 4'd3);
        send4(2'd1, 4'd3, 4'd3, 4'd3, 4'd3);
        send4(2'd2, 4'd3, 4'd3, 4'd3, 4'd3);
        send4(2'd3, 4'd3, 4'd3, 4'd3, 4'd3);
        expect_pub(3, 3, 3, 3);
        wait_empty();
        repeat (3) @(negedge clock);
        chk("scoreboard_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
